led_pwm_fader: RTL and testbench
================================

LED_PWM_FADER -- requirements
Module: led_pwm_fader

Interface
REQ-001 Parameter NUM_LEDS, default 10: number of LED channels; matches the LED PIO output width.
REQ-002 Parameter PRESCALE, default 50: clk cycles per PWM slot; legal range 1 to 65535.
REQ-003 Parameter FADE_STEP_PERIODS, default 4: PWM periods per one-level brightness step; legal range 1 to 255.
REQ-004 Port clk, input, 1: single system clock; all logic is on its rising edge.
REQ-005 Port reset_n, input, 1: asynchronous active-low reset.
REQ-006 Port led_req, input, NUM_LEDS: requested on/off state per LED, driven by the LED PIO out_port.
REQ-007 Port enable, input, 1: 1 = fade mode; 0 = bypass mode.
REQ-008 Port led_out, output, NUM_LEDS: registered PWM drive to the board LEDs.
REQ-009 Port busy, output, 1: registered flag, 1 while any channel level differs from its target.

Function
REQ-010 The block SHALL keep a prescaler counting 0..PRESCALE-1 and wrapping to 0; slot_tick is asserted in the cycle it equals PRESCALE-1.
REQ-011 The block SHALL keep a 4-bit pwm_cnt that advances on slot_tick, counting 0..14 and wrapping 14->0 (15 slots); period_tick = slot_tick AND pwm_cnt==14.
REQ-012 The block SHALL keep a fade_cnt that advances on period_tick, counting 0..FADE_STEP_PERIODS-1 and wrapping; step_tick = period_tick AND fade_cnt==FADE_STEP_PERIODS-1.
REQ-013 Counters SHALL run freely in both modes and are never cleared except by reset.
REQ-014 Each channel i SHALL hold a 4-bit level (0..15); target_i = 15 if led_req[i]=1, else 0.
REQ-015 In fade mode, on step_tick only, each level SHALL move one step toward its target (+1 or -1) and hold when equal; the level never wraps past 0 or 15.
REQ-016 A led_req change mid-fade SHALL reverse direction at the next step_tick from the current level, with no restart from 0 or 15.
REQ-017 In bypass mode, each level SHALL load its target every cycle (snap).
REQ-018 led_out[i] SHALL be registered as (level_i > pwm_cnt): level 0 is always off and level 15 is always on; one clk latency from level/pwm_cnt to pin.
REQ-019 busy SHALL be registered as the OR over channels of (level_i != target_i), evaluated on the next-state levels.
REQ-020 An enable 1->0 transition SHALL snap all levels on the following edge; a 0->1 transition SHALL resume fading with no change to the counters.

Reset
REQ-021 On reset_n=0, the prescaler, pwm_cnt, fade_cnt, all levels, led_out and busy SHALL clear to 0 asynchronously.
REQ-022 After reset deassertion, the first prescaler increment SHALL occur on the first clk edge with reset_n=1.
REQ-023 Reset asserted mid-fade SHALL discard all progress; on release, fading restarts from level 0.

Structure
REQ-024 Package led_fx_pkg SHALL hold LEVEL_W=4, LEVEL_MAX=15, PWM_SLOTS=15 and the pwm_cnt width.
REQ-025 Sub-module led_pwm_channel SHALL hold one channel (level register, step/snap logic, compare, led_out bit) and be instantiated NUM_LEDS times.
REQ-026 The shared prescaler, pwm_cnt, fade_cnt and the busy OR-reduction SHALL live in the top module.

Verification (PRESCALE=2, FADE_STEP_PERIODS=1 unless noted; step period = 30 cycles)
REQ-027 Reset, then led_req=0x000 with enable=1 held -> led_out=0x000 and busy=0 for 1000 cycles.
REQ-028 led_req 0x000->0x001, enable=1 -> busy=1 on the next edge; bit0 reaches a 100% duty cycle after 15 step_ticks (about 450 cycles) and busy then drops to 0; bits 9:1 stay 0.
REQ-029 led_req bit0 set, then cleared after 5 step_ticks -> level rises to 5, then falls 5,4,...,0 with no jump; led_out[0] duty cycle = 5/15 immediately before the reversal.
REQ-030 enable=0 with led_req=0x3FF -> led_out=0x3FF two edges later and busy=0; enable back to 1 with led_req=0x000 -> fade-down over 15 step_ticks.
REQ-031 reset_n pulsed low mid-fade at level 8 -> led_out=0x000 and busy=0 immediately; after release, fade restarts from 0.
REQ-032 Default parameters, led_req=0x200 -> led_out[9] duty cycle steps by one slot every 3000 cycles (50 x 15 x 4).

Source files
------------

// File: rtl/led_fx_pkg.sv
// Shared constants and helpers for the LED PWM fader: 4-bit brightness levels
// compared against a 15-slot PWM counter.
package led_fx_pkg;

    localparam int LEVEL_W   = 4;
    localparam int PWM_W     = 4;
    localparam int PWM_SLOTS = 15;

    typedef logic [LEVEL_W-1:0] level_t;
    typedef logic [PWM_W-1:0]   pwm_t;

    localparam level_t LEVEL_MAX = 4'd15;
    localparam level_t LEVEL_MIN = 4'd0;
    localparam pwm_t   PWM_LAST  = 4'(PWM_SLOTS - 1);

    // One step toward the target; saturates naturally because it stops on equality.
    function automatic level_t step_toward(input level_t level, input level_t target);
        level_t result;
        if (level < target) begin
            result = level + 4'd1;
        end else if (level > target) begin
            result = level - 4'd1;
        end else begin
            result = level;
        end
        return result;
    endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: brightness level register with fade/snap update and the
// registered PWM compare that drives the pin.
module led_pwm_channel
    import led_fx_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic req,
    input  logic enable,
    input  logic step_tick,
    input  pwm_t pwm_cnt,
    output logic led,
    output logic mismatch
);

    level_t target_s;
    level_t level_next_s;
    level_t level_r;
    logic   led_r;

    assign target_s = req ? LEVEL_MAX : LEVEL_MIN;

    // Next level: snap in bypass, one step per step_tick in fade mode.
    always_comb begin
        level_next_s = level_r;
        if (!enable) begin
            level_next_s = target_s;
        end else if (step_tick) begin
            level_next_s = step_toward(level_r, target_s);
        end else begin
            level_next_s = level_r;
        end
    end

    // Level storage and PWM compare; level 15 beats every pwm_cnt value 0..14.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_r <= LEVEL_MIN;
            led_r   <= 1'b0;
        end else begin
            level_r <= level_next_s;
            led_r   <= (level_r > pwm_cnt);
        end
    end

    assign led      = led_r;
    assign mismatch = (level_next_s != target_s);

endmodule

// File: rtl/led_pwm_fader.sv
// Multi-channel LED PWM fader: shared free-running prescaler / PWM / fade
// counters feeding NUM_LEDS per-channel level registers.
module led_pwm_fader
    import led_fx_pkg::*;
#(
    parameter int unsigned NUM_LEDS          = 10,
    parameter int unsigned PRESCALE          = 50,
    parameter int unsigned FADE_STEP_PERIODS = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_LEDS-1:0] led_req,
    input  logic                enable,
    output logic [NUM_LEDS-1:0] led_out,
    output logic                busy
);

    localparam logic [15:0] PRESCALE_LAST = 16'(PRESCALE - 1);
    localparam logic [7:0]  FADE_LAST     = 8'(FADE_STEP_PERIODS - 1);

    logic [15:0]         prescale_r;
    pwm_t                pwm_cnt_r;
    logic [7:0]          fade_cnt_r;
    logic                busy_r;
    logic                slot_tick_s;
    logic                period_tick_s;
    logic                step_tick_s;
    logic [NUM_LEDS-1:0] mismatch_s;

    assign slot_tick_s   = (prescale_r == PRESCALE_LAST);
    assign period_tick_s = slot_tick_s && (pwm_cnt_r == PWM_LAST);
    assign step_tick_s   = period_tick_s && (fade_cnt_r == FADE_LAST);

    // Timebase counters run regardless of enable; only reset clears them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescale_r <= 16'd0;
            pwm_cnt_r  <= 4'd0;
            fade_cnt_r <= 8'd0;
        end else begin
            prescale_r <= slot_tick_s ? 16'd0 : prescale_r + 16'd1;
            if (slot_tick_s) begin
                pwm_cnt_r <= (pwm_cnt_r == PWM_LAST) ? 4'd0 : pwm_cnt_r + 4'd1;
            end
            if (period_tick_s) begin
                fade_cnt_r <= (fade_cnt_r == FADE_LAST) ? 8'd0 : fade_cnt_r + 8'd1;
            end
        end
    end

    // busy reflects next-state levels, so it rises with the request change.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= |mismatch_s;
        end
    end

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
        led_pwm_channel u_ch (
            .clk       (clk),
            .reset_n   (reset_n),
            .req       (led_req[i]),
            .enable    (enable),
            .step_tick (step_tick_s),
            .pwm_cnt   (pwm_cnt_r),
            .led       (led_out[i]),
            .mismatch  (mismatch_s[i])
        );
    end

    assign busy = busy_r;

endmodule

// File: tb/tb_led_pwm_fader.sv
// Directed bench: fast instance (PRESCALE=2, FADE_STEP_PERIODS=1, 30-cycle step)
// plus a default-parameter instance for the slow-timebase check.
module tb_led_pwm_fader;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [9:0] led_req;
    logic [9:0] led_req_d;
    logic       enable;
    logic [9:0] led_out;
    logic [9:0] led_out_d;
    logic       busy;
    logic       busy_d;

    int errors = 0;
    int checks = 0;
    int e;

    always #5 clk = ~clk;

    // Edge count since reset release; level steps land on multiples of 30.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) e <= 0;
        else          e <= e + 1;
    end

    led_pwm_fader #(.NUM_LEDS(10), .PRESCALE(2), .FADE_STEP_PERIODS(1)) dut (
        .clk(clk), .reset_n(reset_n), .led_req(led_req), .enable(enable),
        .led_out(led_out), .busy(busy)
    );

    led_pwm_fader dut_d (
        .clk(clk), .reset_n(reset_n), .led_req(led_req_d), .enable(enable),
        .led_out(led_out_d), .busy(busy_d)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic align();
        while (e % 30 != 0) step();
    endtask

    task automatic measure(input int n, output int ones0, output int ones9,
                           output logic b_first, output logic b_last);
        ones0 = 0; ones9 = 0; b_first = 1'b0; b_last = 1'b0;
        for (int k = 0; k < n; k++) begin
            step();
            if (k == 0)     b_first = busy;
            if (k == n - 1) b_last  = busy;
            ones0 += int'(led_out[0]);
            ones9 += int'(led_out[9]);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; led_req = 10'h000; led_req_d = 10'h000; enable = 1'b1;
        #1;
        checks++; if (led_out !== 10'h000) begin errors++; $display("FAIL reset_led_out: got %h expected 000", led_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (led_out_d !== 10'h000 || busy_d !== 1'b0) begin errors++; $display("FAIL reset_default_inst: led_out=%h busy=%b expected 000/0", led_out_d, busy_d); end
        step(); step();
        @(negedge clk) reset_n = 1'b1;
    endtask

    task automatic test_idle();
        for (int k = 0; k < 1000; k++) begin
            step();
            checks++;
            if (led_out !== 10'h000 || busy !== 1'b0) begin
                errors++; $display("FAIL idle cycle %0d: led_out=%h busy=%b expected 000/0", k, led_out, busy);
            end
        end
    endtask

    task automatic test_fade_up();
        int o0, o9; logic bf, bl;
        align();
        led_req = 10'h001;
        step();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fade_up_busy_rise: got %b expected 1", busy); end
        align();
        for (int m = 1; m <= 15; m++) begin
            measure(30, o0, o9, bf, bl);
            checks++; if (o0 != 2 * m) begin errors++; $display("FAIL fade_up_duty level %0d: got %0d expected %0d", m, o0, 2 * m); end
            checks++; if (o9 != 0) begin errors++; $display("FAIL fade_up_bit9 level %0d: got %0d expected 0", m, o9); end
            checks++; if (bf !== (m < 15)) begin errors++; $display("FAIL fade_up_busy level %0d: got %b expected %b", m, bf, (m < 15)); end
            if (m == 14) begin
                checks++; if (bl !== 1'b0) begin errors++; $display("FAIL fade_up_busy_drop: got %b expected 0", bl); end
            end
        end
        checks++; if (led_out !== 10'h001) begin errors++; $display("FAIL fade_up_final: got %h expected 001", led_out); end
    endtask

    task automatic test_reverse();
        int o0, o9; logic bf, bl;
        int exp_lvl [11] = '{0, 1, 2, 3, 4, 5, 4, 3, 2, 1, 0};
        enable = 1'b0; led_req = 10'h000;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL snap_busy: got %b expected 0", busy); end
        step();
        align();
        enable = 1'b1; led_req = 10'h001;
        for (int w = 0; w < 11; w++) begin
            if (w == 5) led_req = 10'h000;
            measure(30, o0, o9, bf, bl);
            checks++; if (o0 != 2 * exp_lvl[w]) begin errors++; $display("FAIL reverse_duty window %0d: got %0d expected %0d", w, o0, 2 * exp_lvl[w]); end
        end
    endtask

    task automatic test_bypass();
        int o0, o9; logic bf, bl;
        enable = 1'b0; led_req = 10'h3FF;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bypass_busy: got %b expected 0", busy); end
        step();
        checks++; if (led_out !== 10'h3FF) begin errors++; $display("FAIL bypass_led_out: got %h expected 3ff", led_out); end
        measure(30, o0, o9, bf, bl);
        checks++; if (o0 != 30 || o9 != 30 || bf !== 1'b0) begin errors++; $display("FAIL bypass_hold: ones0=%0d ones9=%0d busy=%b expected 30/30/0", o0, o9, bf); end
        align();
        enable = 1'b1; led_req = 10'h000;
        for (int m = 0; m <= 15; m++) begin
            measure(30, o0, o9, bf, bl);
            checks++; if (o0 != 2 * (15 - m) || o9 != 2 * (15 - m)) begin errors++; $display("FAIL fade_down_duty window %0d: ones0=%0d ones9=%0d expected %0d", m, o0, o9, 2 * (15 - m)); end
            checks++; if (bf !== (m < 15)) begin errors++; $display("FAIL fade_down_busy window %0d: got %b expected %b", m, bf, (m < 15)); end
        end
    endtask

    task automatic test_reset_mid();
        int o0, o9; logic bf, bl;
        align();
        led_req = 10'h3FF;
        for (int m = 0; m < 8; m++) begin
            measure(30, o0, o9, bf, bl);
            checks++; if (o9 != 2 * m) begin errors++; $display("FAIL pre_reset_duty window %0d: got %0d expected %0d", m, o9, 2 * m); end
        end
        for (int k = 0; k < 5; k++) step();
        checks++; if (busy !== 1'b1 || led_out !== 10'h3FF) begin errors++; $display("FAIL level8_state: busy=%b led_out=%h expected 1/3ff", busy, led_out); end
        reset_n = 1'b0;
        #1;
        checks++; if (led_out !== 10'h000 || busy !== 1'b0) begin errors++; $display("FAIL mid_reset: led_out=%h busy=%b expected 000/0", led_out, busy); end
        step(); step();
        led_req_d = 10'h200;
        @(negedge clk) reset_n = 1'b1;
        measure(30, o0, o9, bf, bl);
        checks++; if (o9 != 0 || bf !== 1'b1) begin errors++; $display("FAIL restart_window0: ones=%0d busy=%b expected 0/1", o9, bf); end
        measure(30, o0, o9, bf, bl);
        checks++; if (o9 != 2) begin errors++; $display("FAIL restart_window1: got %0d expected 2", o9); end
    endtask

    task automatic test_default_params();
        int ones, stray;
        for (int m = 1; m <= 3; m++) begin
            while (e % 3000 != 0) step();
            ones = 0; stray = 0;
            for (int k = 0; k < 750; k++) begin
                step();
                ones += int'(led_out_d[9]);
                if (led_out_d[8:0] !== 9'h000) stray++;
            end
            checks++; if (ones != 50 * m) begin errors++; $display("FAIL default_duty level %0d: got %0d expected %0d", m, ones, 50 * m); end
            checks++; if (stray != 0) begin errors++; $display("FAIL default_other_bits level %0d: got %0d expected 0", m, stray); end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_fade_up();
        test_reverse();
        test_bypass();
        test_reset_mid();
        test_default_params();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
